// File: rtl/fetch_inst_buffer_pkg.sv
// fetch_inst_buffer_pkg: shared frontend widths, fetch entry type and bit-count helper
package fetch_inst_buffer_pkg;

    localparam int FETCH_WIDTH  = 4;
    localparam int DECODE_WIDTH = 4;
    localparam int IBUF_DEPTH   = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  ftq_offset;
    } fetchEntry_t;

    function automatic int count_one(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: decoupling queue between fetch s3 and decode with occupancy-based stall
module fetch_inst_buffer
    import fetch_inst_buffer_pkg::*;
#(
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int IN_WIDTH  = FETCH_WIDTH,
    parameter int OUT_WIDTH = DECODE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_squash_vld,
    input  logic [IN_WIDTH-1:0]  i_fetch_inst_vld,
    input  fetchEntry_t          i_fetch_inst [IN_WIDTH],
    output logic                 o_stall,
    input  logic                 i_decode_rdy,
    output logic [OUT_WIDTH-1:0] o_inst_vld,
    output fetchEntry_t          o_inst [OUT_WIDTH]
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    fetchEntry_t   r_entries [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [PW-1:0] w_count, w_free, w_enq_num, w_deq_num;
    logic          w_enq_fire, w_deq_fire;

    always_comb begin
        w_count    = r_tail - r_head;
        w_free     = PW'(DEPTH) - w_count;
        w_enq_num  = PW'(count_one(32'(i_fetch_inst_vld)));
        w_deq_num  = (w_count < PW'(OUT_WIDTH)) ? w_count : PW'(OUT_WIDTH);
        w_enq_fire = |i_fetch_inst_vld && !o_stall && !i_squash_vld;
        w_deq_fire = i_decode_rdy && (w_count != '0) && !i_squash_vld;
    end

    // Stall depends only on registered pointers, so the fetcher sees no input-to-stall path
    assign o_stall = w_free < PW'(IN_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_squash_vld) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + w_enq_num;
            if (w_deq_fire) r_head <= r_head + w_deq_num;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_WIDTH; k++)
            if (w_enq_fire && PW'(k) < w_enq_num)
                r_entries[r_tail[IW-1:0] + IW'(k)] <= i_fetch_inst[k];
    end

    for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_out
        assign o_inst_vld[k] = w_count > PW'(k);
        assign o_inst[k]     = r_entries[r_head[IW-1:0] + IW'(k)];
    end

    a_vld_contig: assert property (@(posedge clk) disable iff (rst)
        (i_fetch_inst_vld & (i_fetch_inst_vld + IN_WIDTH'(1))) == '0);
    a_count_max: assert property (@(posedge clk) disable iff (rst) w_count <= PW'(DEPTH));
    a_no_enq_stall: assert property (@(posedge clk) disable iff (rst) !(w_enq_fire && o_stall));

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb_fetch_inst_buffer: scoreboard bench for the fetch instruction buffer
module tb_fetch_inst_buffer;
    import fetch_inst_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int OW    = 4;

    logic          clk = 0, rst = 1, squash = 0, rdy = 0;
    logic [IW-1:0] vld = '0;
    fetchEntry_t   fin [IW];
    logic          stall;
    logic [OW-1:0] ovld;
    fetchEntry_t   oinst [OW];

    fetchEntry_t   sb[$], got_q[$], exp_q[$];
    int            errors = 0, checks = 0;
    logic [31:0]   next_tag = 32'h100;

    always #5 clk = ~clk;

    fetch_inst_buffer dut (
        .clk(clk), .rst(rst), .i_squash_vld(squash),
        .i_fetch_inst_vld(vld), .i_fetch_inst(fin), .o_stall(stall),
        .i_decode_rdy(rdy), .o_inst_vld(ovld), .o_inst(oinst)
    );

    // One clock: drive n contiguous lanes, capture consumed outputs, advance the reference queue
    task automatic cycle(input int n, input logic r, input logic sq);
        logic model_stall;
        vld = '0;
        for (int k = 0; k < IW; k++) begin
            fin[k].inst       = next_tag + 32'(k);
            fin[k].ftq_offset = 5'(2 * k);
            if (k < n) vld[k] = 1'b1;
        end
        rdy = r;
        squash = sq;
        model_stall = (DEPTH - sb.size()) < IW;
        if (r && !sq)
            for (int k = 0; k < OW; k++) if (ovld[k]) got_q.push_back(oinst[k]);
        if (sq) sb.delete();
        else begin
            if (r) for (int k = 0; k < OW && sb.size() > 0; k++) exp_q.push_back(sb.pop_front());
            if (n > 0 && !model_stall) for (int k = 0; k < n; k++) sb.push_back(fin[k]);
        end
        next_tag += 32'(IW);
        @(posedge clk); #1;
        vld = '0;
        rdy = 0;
        squash = 0;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && sb.size() > 0; c++) cycle(0, 1, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout remaining=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ovld !== '0) begin errors++; $display("FAIL reset_vld got=%b exp=0000", ovld); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        cycle(3, 0, 0);
        checks++; if (ovld !== 4'b0111) begin errors++; $display("FAIL basic_vld got=%b exp=0111", ovld); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_stall got=%b exp=0", stall); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (oinst[k].ftq_offset !== 5'(2 * k)) begin
                errors++;
                $display("FAIL basic_offset lane=%0d got=%0d exp=%0d", k, oinst[k].ftq_offset, 2 * k);
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=3", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_order i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill_stall();
        repeat (3) cycle(4, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill12_stall got=%b exp=0", stall); end
        checks++; if (ovld !== 4'b1111) begin errors++; $display("FAIL fill12_vld got=%b exp=1111", ovld); end
        cycle(1, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill13_stall got=%b exp=1", stall); end
        cycle(4, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_ignored_stall got=%b exp=1", stall); end
    endtask

    task automatic test_boundary();
        cycle(4, 1, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL boundary_stall_fall got=%b exp=0", stall); end
        checks++; if (ovld !== 4'b1111) begin errors++; $display("FAIL boundary_vld got=%b exp=1111", ovld); end
        cycle(4, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL boundary_refill_stall got=%b exp=1", stall); end
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 17) begin
            errors++;
            $display("FAIL boundary_count got=%0d exp=17", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL boundary_order i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        int sent = 0;
        for (int c = 0; c < 200 && (sent < 40 || sb.size() > 0); c++) begin
            int  n   = (sent < 40) ? 4 : 0;
            bit  acc = n > 0 && sb.size() <= DEPTH - IW;
            cycle(n, 1, 0);
            if (acc) sent += n;
        end
        checks++;
        if (got_q.size() != 40 || exp_q.size() != 40) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp=40", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_squash();
        cycle(4, 0, 0);
        cycle(4, 0, 0);
        cycle(2, 0, 0);
        cycle(4, 1, 1);
        checks++; if (ovld !== '0) begin errors++; $display("FAIL squash_vld got=%b exp=0000", ovld); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL squash_stall got=%b exp=0", stall); end
        cycle(3, 0, 0);
        checks++; if (ovld !== 4'b0111) begin errors++; $display("FAIL squash_fresh_vld got=%b exp=0111", ovld); end
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 3) begin
            errors++;
            $display("FAIL squash_count got=%0d exp=3", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL squash_order i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_async_reset();
        cycle(4, 0, 0);
        cycle(3, 0, 0);
        checks++; if (ovld !== 4'b1111) begin errors++; $display("FAIL areset_pre_vld got=%b exp=1111", ovld); end
        #2 rst = 1;
        #1;
        checks++; if (ovld !== '0) begin errors++; $display("FAIL areset_vld got=%b exp=0000", ovld); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL areset_stall got=%b exp=0", stall); end
        sb.delete();
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        checks++; if (ovld !== '0) begin errors++; $display("FAIL areset_post_vld got=%b exp=0000", ovld); end
    endtask

    initial begin
        for (int k = 0; k < IW; k++) fin[k] = '0;
        test_reset();
        test_basic();
        test_fill_stall();
        test_boundary();
        test_wrap();
        test_squash();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_inst_buffer.md
# fetch_inst_buffer

Decoupling queue between the fetcher's s3 output and decode. Accepts up to `IN_WIDTH` compacted fetch entries per cycle and presents up to `OUT_WIDTH` oldest entries to decode in program order. Generates the fetcher's backend stall from its own occupancy. Flushes completely on a backend squash.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two; must be ≥ `IN_WIDTH`+`OUT_WIDTH`.
- `IN_WIDTH`, `FETCH_WIDTH`: enqueue lanes.
- `OUT_WIDTH`, `DECODE_WIDTH`: dequeue lanes.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `i_squash_vld`  in  1  backend squash; flushes the buffer.
- `i_fetch_inst_vld`  in  `IN_WIDTH`  per-lane valid from fetcher; contiguous from lane 0.
- `i_fetch_inst`  in  `fetchEntry_t[IN_WIDTH]`  fetch entries.
- `o_stall`  out  1  to the fetcher's `i_backend_stall`; input is ignored while high.
- `i_decode_rdy`  in  1  decode accepts every valid output lane this cycle.
- `o_inst_vld`  out  `OUT_WIDTH`  per-lane valid; contiguous from lane 0.
- `o_inst`  out  `fetchEntry_t[OUT_WIDTH]`  oldest entries; lane 0 is oldest.

## Operation
State:
- `entries[DEPTH]` storage.
- `head` and `tail` pointers, `$clog2(DEPTH)+1` bits each; the MSB is the wrap bit.
- `count = tail - head`, taken modulo 2^(ptr bits). Full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.

Control:
- `free = DEPTH - count`.
- `o_stall = (free < IN_WIDTH)`, driven from registered state only.
- `enq_fire = |i_fetch_inst_vld && !o_stall && !i_squash_vld`.
- `enq_num = funcs::count_one(i_fetch_inst_vld)`.

Enqueue:
- Lane k writes `entries[(tail+k) mod DEPTH]` for each k < `enq_num`.
- Then `tail += enq_num`.

Dequeue:
- Outputs: `o_inst_vld[k] = (count > k)`; `o_inst[k] = entries[(head+k) mod DEPTH]`.
- Invalid output lanes carry don't-care data.
- `deq_fire = i_decode_rdy && (count != 0) && !i_squash_vld`.
- `deq_num = min(count, OUT_WIDTH)`; then `head += deq_num`.

Boundary and priority rules:
- Enqueue and dequeue in the same cycle are both performed. The stall decision uses the pre-cycle count, which is conservative: a slot freed this cycle is never reused in the same cycle.
- Squash has the highest priority: `head`, `tail` ← 0 at the edge, and same-cycle enqueue and dequeue are discarded. In the cycle after a squash, `o_stall` = 0 and `o_inst_vld` = 0. Storage contents are not cleared.
- Wrap-around: lane index arithmetic is mod `DEPTH`; the pointers wrap naturally through the extra MSB.
- Full: `count` never exceeds `DEPTH`, which follows from the stall rule.

Assertions:
- `i_fetch_inst_vld` is contiguous from lane 0.
- `count ≤ DEPTH`.
- No `enq_fire` while `o_stall` is high.

## Timing
- Reset (asynchronous):
  - `head = tail = 0`.
  - `o_stall = 0`.
  - `o_inst_vld = 0`.
  - `o_inst` is don't-care.
- Latency: an entry enqueued at edge N appears on `o_inst` in the cycle after edge N, so it is one cycle from fetcher s3 to decode.
- `o_stall` changes only after a clock edge and has no combinational path from any input. Because of this the fetcher's s3 register holds its data stably while stalled.
- Dequeue handshake: output lanes are consumed at the edge where `i_decode_rdy` = 1. When `i_decode_rdy` = 0, the outputs hold.
- Sustained throughput is min(`IN_WIDTH`, `OUT_WIDTH`) entries per cycle when `free ≥ IN_WIDTH`.

## Structure
- `fetchEntry_t`, `FETCH_WIDTH` and `DECODE_WIDTH` come from `frontend_define.svh`.
- Add `IBUF_DEPTH` (default 16) to the same header.
- Reuse `funcs::count_one` for `enq_num`.
- No sub-module: a single flat module of about 150 lines, built from pointer arithmetic plus a register-array storage.

## Test plan
- **Basic enqueue:** reset; enqueue `vld=4'b0111` with ftqOffset 0, 2, 4 while `i_decode_rdy=0` → next cycle `o_inst_vld=4'b0111` with offsets 0, 2, 4 in lanes 0–2, and `o_stall=0`.
- **Fill to stall:** with `DEPTH=16` and `IN_WIDTH=4`, enqueue 4 entries for 3 cycles with decode blocked → `count=12`, `free=4`, `o_stall=0`. Enqueue 1 more entry → `count=13`, `o_stall=1`. Further valid input is not written and `count` stays 13.
- **Wrap-around:** stream 40 sequentially tagged entries with decode always ready → decode observes all 40 in order, with no gaps or duplicates across pointer wraps.
- **Simultaneous enqueue/dequeue at the boundary:** `count=13` (stall high), `i_decode_rdy=1` → `deq_num=4`, `count=9`. `o_stall` falls the next cycle, and the entries enqueued next land after the remaining 9 in order.
- **Squash with traffic:** assert `i_squash_vld` together with enqueue and `i_decode_rdy` at `count=10` → next cycle `o_inst_vld=0`, `o_stall=0`, `count=0`. A fresh enqueue is then emitted correctly starting at slot 0.
- **Asynchronous reset mid-operation:** assert `rst` between edges at `count=7` → `o_inst_vld` = 0 and `o_stall` = 0 immediately, without waiting for a clock edge.
